// File: rtl/paddle_input_pkg.sv
// paddle_input_pkg
//   Shared types and default timing constants for the paddle command source.
//   Holds the direction FSM state type, the held-direction type, the default
//   timing values (sized for a 50 MHz board clock) and a small helper that
//   turns the two debounced direction buttons into a single direction.
//   Build option INPUT_ACCEL_EN (see paddle_input_ctrl) does not affect this file.

package paddle_input_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  typedef enum logic [1:0] {NONE, L, R} dir_t;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd2000000;
  localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd250000;
  localparam logic [7:0]  DEF_ACCEL_AFTER     = 8'd8;

  // Pressing both buttons at once is treated the same as pressing neither,
  // so the paddle never receives contradictory step requests.
  function automatic dir_t decode_dir(input logic left, input logic right);
    dir_t d;
    d = NONE;
    if (left && !right) begin
      d = L;
    end else if (right && !left) begin
      d = R;
    end
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Conditions one raw push-button: 2-FF synchroniser, consecutive-sample
//   debounce counter and a registered rising-edge pulse.
//   Ports:
//     clk    in  1  system clock
//     reset  in  1  synchronous, active-high reset
//     btn    in  1  raw asynchronous button, active-high
//     level  out 1  debounced button level
//     rise   out 1  one-cycle pulse, registered together with level going 1

module btn_debounce
  import paddle_input_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 16'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 16'd1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Synchronise the raw pin, then count consecutive samples that disagree
  // with the current debounced level. The level flips on the sample that
  // completes the run; any agreeing sample restarts the run from zero.
  // The rise pulse is registered in the same edge as the level so the
  // consumer sees both on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl
//   Command source for the paddle block. Debounces the four board buttons and
//   turns them into left/right one-pixel step strobes with hold-to-repeat, a
//   pause level toggled by the pause button and a one-cycle start pulse.
//   Ports:
//     clk         in  1  system clock
//     reset       in  1  synchronous, active-high reset
//     btn_left    in  1  raw left button
//     btn_right   in  1  raw right button
//     btn_pause   in  1  raw pause button
//     btn_start   in  1  raw start button
//     move_left   out 1  one-cycle step strobe, move one pixel left
//     move_right  out 1  one-cycle step strobe, move one pixel right
//     pause       out 1  pause level
//     start       out 1  one-cycle start pulse
//   Build option: define INPUT_ACCEL_EN to halve the auto-repeat period once
//   ACCEL_AFTER repeat strobes have been issued in one continuous hold.

module paddle_input_ctrl
  import paddle_input_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [7:0]  ACCEL_AFTER     = DEF_ACCEL_AFTER
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_pause,
  input  logic btn_start,
  output logic move_left,
  output logic move_right,
  output logic pause,
  output logic start
);

  // One shared down-counter serves both the initial delay and the repeat period.
  localparam logic [23:0] CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = (CNT_MAX > 24'd1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 24'd1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 24'd1);

  logic left_level, left_rise;
  logic right_level, right_rise;
  logic pause_level, pause_rise;
  logic start_level, start_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset(reset), .btn(btn_left), .level(left_level), .rise(left_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset(reset), .btn(btn_right), .level(right_level), .rise(right_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .reset(reset), .btn(btn_pause), .level(pause_level), .rise(pause_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .btn(btn_start), .level(start_level), .rise(start_rise)
  );

  state_t          state;
  dir_t            cur_dir;
  dir_t            dir;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] repeat_load;
  logic            pause_next;
  logic            hold_ok;
  logic            new_press;
  logic            cnt_zero;
  logic            unused_sigs;

  assign dir       = decode_dir(left_level, right_level);
  assign cnt_zero  = (cnt == '0);
  // Stepping is blocked both while paused and on the edge that enters pause,
  // so no strobe ever coincides with pause=1. Leaving pause takes effect one
  // cycle later, once the pause register itself has cleared.
  assign hold_ok   = (dir != NONE) && !pause && !pause_next;
  assign new_press = hold_ok && ((state == IDLE) || (dir != cur_dir));

  // Start has priority over a simultaneous pause edge and always unpauses.
  always_comb begin
    pause_next = pause;
    if (start_rise) begin
      pause_next = 1'b0;
    end else if (pause_rise) begin
      pause_next = ~pause;
    end
  end

  // Pause level and start pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause <= 1'b0;
      start <= 1'b0;
    end else begin
      pause <= pause_next;
      start <= start_rise;
    end
  end

`ifdef INPUT_ACCEL_EN
  localparam int ACC_W = (ACCEL_AFTER > 8'd1) ? $clog2(int'(ACCEL_AFTER) + 1) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX   = ACC_W'(ACCEL_AFTER);
  localparam logic [CNT_W-1:0] FAST_LOAD = CNT_W'((REPEAT_PERIOD >> 1) - 24'd1);

  logic [ACC_W-1:0] acc_cnt;
  logic [ACC_W-1:0] acc_next;

  assign acc_next    = (acc_cnt == ACC_MAX) ? acc_cnt : acc_cnt + 1'b1;
  // The strobe that completes the ACCEL_AFTER-th repeat already picks the
  // short reload, so the faster cadence starts right after it.
  assign repeat_load = (acc_next == ACC_MAX) ? FAST_LOAD : PERIOD_LOAD;

  // Count repeat strobes within one continuous hold; any release, pause or
  // direction change drops the FSM out of REPEAT and clears the count.
  always_ff @(posedge clk) begin
    if (reset || !hold_ok || new_press) begin
      acc_cnt <= '0;
    end else if ((state == REPEAT) && cnt_zero) begin
      acc_cnt <= acc_next;
    end
  end

  assign unused_sigs = ^{left_rise, right_rise, pause_level, start_level};
`else
  assign repeat_load = PERIOD_LOAD;
  assign unused_sigs = ^{left_rise, right_rise, pause_level, start_level, ACCEL_AFTER};
`endif

  // Direction FSM. A new press (from IDLE, or a direct L<->R swap) steps
  // immediately and arms the long initial delay; afterwards the counter runs
  // down to zero, steps, and reloads the repeat period. Losing a valid
  // direction or pausing returns to IDLE without stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_dir    <= NONE;
      cnt        <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      if (!hold_ok) begin
        state   <= IDLE;
        cur_dir <= NONE;
      end else if (new_press) begin
        move_left  <= (dir == L);
        move_right <= (dir == R);
        cnt        <= DELAY_LOAD;
        cur_dir    <= dir;
        state      <= DELAY;
      end else if (!cnt_zero) begin
        cnt <= cnt - 1'b1;
      end else begin
        move_left  <= (cur_dir == L);
        move_right <= (cur_dir == R);
        state      <= REPEAT;
        cnt        <= (state == DELAY) ? PERIOD_LOAD : repeat_load;
      end
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl
//   Directed bench for paddle_input_ctrl with small timing values
//   (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, ACCEL_AFTER=2).
//   Inputs change just after a falling edge; outputs are sampled on the
//   falling edge, so tick N of a window is the output after the Nth rising edge
//   following the input change. Expected outputs are given as bit masks
//   indexed by tick number. Expectations follow INPUT_ACCEL_EN when defined.

module tb_paddle_input_ctrl;
  import paddle_input_pkg::*;

  localparam logic [15:0] TB_DEBOUNCE = 16'd4;
  localparam logic [23:0] TB_DELAY    = 24'd10;
  localparam logic [23:0] TB_PERIOD   = 24'd5;
  localparam logic [7:0]  TB_ACCEL    = 8'd2;

  logic clk = 1'b0;
  logic reset;
  logic btn_left, btn_right, btn_pause, btn_start;
  logic move_left, move_right, pause, start;

  int assertCount = 0;
  int failCount   = 0;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(TB_DEBOUNCE),
    .REPEAT_DELAY(TB_DELAY),
    .REPEAT_PERIOD(TB_PERIOD),
    .ACCEL_AFTER(TB_ACCEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_pause(btn_pause),
    .btn_start(btn_start),
    .move_left(move_left),
    .move_right(move_right),
    .pause(pause),
    .start(start)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] pt(input int a);
    return 64'd1 << a;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic p, input logic s);
    btn_left  = l;
    btn_right = r;
    btn_pause = p;
    btn_start = s;
  endtask

  task automatic checkOutput(input string tag, input logic expL, input logic expR,
                             input logic expP, input logic expS);
    assertCount++;
    assert (move_left === expL) else begin
      failCount++;
      $error("[TB] FAIL %s move_left observed=%b expected=%b", tag, move_left, expL);
    end
    assertCount++;
    assert (move_right === expR) else begin
      failCount++;
      $error("[TB] FAIL %s move_right observed=%b expected=%b", tag, move_right, expR);
    end
    assertCount++;
    assert (pause === expP) else begin
      failCount++;
      $error("[TB] FAIL %s pause observed=%b expected=%b", tag, pause, expP);
    end
    assertCount++;
    assert (start === expS) else begin
      failCount++;
      $error("[TB] FAIL %s start observed=%b expected=%b", tag, start, expS);
    end
    assertCount++;
    assert ((move_left & move_right) === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL %s exclusive observed=%b%b expected=not both", tag, move_left, move_right);
    end
  endtask

  task automatic runWindow(input string tag, input int n, input logic [63:0] mL,
                           input logic [63:0] mR, input logic [63:0] mP, input logic [63:0] mS);
    for (int i = 1; i <= n; i++) begin
      tick();
      checkOutput($sformatf("%s[%0d]", tag, i), mL[i], mR[i], mP[i], mS[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    runWindow("idle", 4, '0, '0, '0, '0);

    $display("[TB] glitch rejection");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runWindow("glitch_hi", 3, '0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runWindow("glitch_lo", 12, '0, '0, '0, '0);

    $display("[TB] left hold with auto-repeat");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef INPUT_ACCEL_EN
    runWindow("hold_left", 34, pt(7) | pt(17) | pt(22) | pt(27) | pt(29) | pt(31) | pt(33),
              '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runWindow("rel_left", 12, pt(1) | pt(3) | pt(5), '0, '0, '0);
`else
    runWindow("hold_left", 34, pt(7) | pt(17) | pt(22) | pt(27) | pt(32), '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runWindow("rel_left", 12, pt(3), '0, '0, '0);
`endif

    $display("[TB] both held, then left released");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runWindow("both_a", 10, pt(7), '0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runWindow("both_b", 20, '0, '0, '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runWindow("both_c", 23, '0, pt(7) | pt(17) | pt(22), '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef INPUT_ACCEL_EN
    runWindow("both_d", 12, '0, pt(4) | pt(6), '0, '0);
`else
    runWindow("both_d", 12, '0, pt(4), '0, '0);
`endif

    $display("[TB] pause and start");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runWindow("pz_hold", 7, '0, pt(7), '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runWindow("pz_on", 14, '0, '0, span(7, 14), '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runWindow("pz_held", 12, '0, '0, span(1, 12), '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runWindow("pz_off", 10, '0, pt(8), span(1, 6), '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runWindow("pz_run", 8, '0, pt(8), '0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runWindow("pz_again", 10, '0, pt(5), span(7, 10), '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    runWindow("start", 12, '0, '0, span(1, 6), pt(7));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runWindow("start_rel", 8, '0, '0, '0, '0);

    $display("[TB] reset mid-repeat");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runWindow("rst_hold", 24, pt(7) | pt(17) | pt(22), '0, '0, '0);
    reset = 1'b1;
    runWindow("rst_on", 2, '0, '0, '0, '0);
    reset = 1'b0;
    runWindow("rst_off", 10, pt(7), '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runWindow("rst_rel", 12, '0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
